matmul_tile_sequencer: RTL and testbench
========================================

# matmul_tile_sequencer

- Sequences a K-dimension tiled matrix multiply-accumulate through one `matrix_multiplication_accumulation` instance.
- Keeps the running M×N accumulator and issues one A/B tile per MAC transaction, with C = current accumulator. It captures D back into the accumulator and emits the final result after the last tile.
- Sits between the tile fetch buffer and the MAC unit.
- Only one MAC transaction is in flight at a time, because of the accumulate dependency.

## Interface
Parameters:
- `M`, default 2, rows of A/C/D.
- `N`, default 2, columns of B/C/D.
- `K`, default 2, inner dimension per tile.
- `P`, default 8, operand width; accumulator elements are 4*P.
- `KT_W`, default 8, width of the tile-count field.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `cmd_valid_i` in 1 / `cmd_ready_o` out 1: command handshake.
- `cmd_ktiles_i` in KT_W: number of K-tiles to accumulate (0 allowed).
- `cmd_bias_i` in M*N*4*P: initial accumulator value.
- `tile_valid_i` in 1 / `tile_ready_o` out 1: tile stream handshake.
- `tile_a_i` in M*K*P, `tile_b_i` in K*N*P: tile operands.
- `mac_valid_o` out 1 / `mac_ready_i` in 1: MAC input handshake; connects to the MAC's `valid_in` / `ready_in`.
- `mac_a_o` out M*K*P, `mac_b_o` out K*N*P, `mac_c_o` out M*N*4*P: MAC operands.
- `mac_valid_i` in 1 / `mac_ready_o` out 1: MAC output handshake; connects to the MAC's `valid_out` / `ready_out`.
- `mac_d_i` in M*N*4*P: MAC result D.
- `res_valid_o` out 1 / `res_ready_i` in 1 / `res_d_o` out M*N*4*P: final result.
- `busy_o` out 1: high in any state except IDLE.
- `tiles_done_o` out KT_W: count of D results captured for the current command.
- `protocol_err_o` out 1: sticky flag, set on `mac_valid_i` outside WAIT.

Flattening rule for all matrix buses:
- Element (r,c) of an R×C matrix with element width W occupies bits [(r*C+c)*W +: W].

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUT.
- **IDLE**
  - `cmd_ready_o`=1.
  - On cmd handshake: acc<=cmd_bias_i, remaining<=cmd_ktiles_i, tiles_done<=0.
  - Next state is OUT if cmd_ktiles_i==0, else ISSUE.
- **ISSUE**
  - Combinational pass-through:
    - `mac_valid_o`=`tile_valid_i` and `tile_ready_o`=`mac_ready_i`.
    - `mac_a_o`=`tile_a_i`, `mac_b_o`=`tile_b_i`, `mac_c_o`=acc.
  - On handshake (tile_valid_i & mac_ready_i): remaining<=remaining-1, go to WAIT.
- **WAIT**
  - `mac_ready_o`=1.
  - On `mac_valid_i`: acc<=mac_d_i, tiles_done<=tiles_done+1.
  - Next state is OUT if remaining==0, else ISSUE.
- **OUT**
  - `res_valid_o`=1, `res_d_o`=acc.
  - On `res_ready_i`, go to IDLE.
  - acc is held until the next command is accepted.
- Default values outside the listed state:
  - `mac_valid_o`, `tile_ready_o`, `mac_ready_o`, `res_valid_o` and `cmd_ready_o` are 0.
  - `mac_a_o`, `mac_b_o`, `mac_c_o` are 0 outside ISSUE.
  - `res_d_o` is 0 outside OUT.
- No arithmetic is done in this block:
  - D is stored bit-exact.
  - Accumulator overflow wraps inside the MAC (4*P two's complement).
- `protocol_err_o` is set when `mac_valid_i`=1 in IDLE, ISSUE or OUT. That D is dropped, and the bit clears only on reset.
- A command cannot be accepted while busy. `cmd_ready_o` is 0 in ISSUE, WAIT and OUT, including the OUT→IDLE handshake cycle.

## Timing
- Reset values: state=IDLE, acc=0, remaining=0, tiles_done_o=0, protocol_err_o=0.
  - All handshake outputs are 0 except `cmd_ready_o`=1 (combinational from IDLE) the cycle after reset.
- Cmd accepted at cycle t: ISSUE at t+1 (`mac_valid_o` can assert at t+1); with ktiles=0, `res_valid_o`=1 at t+1.
- D accepted at cycle t: ISSUE at t+1, or OUT at t+1 after the last tile.
- Per-tile period = 1 + L_mac + 1 cycles minimum, where L_mac = MAC valid_in→valid_out latency (PIPESTAGES-1 for modes 0/1).
- Backpressure: in ISSUE, `mac_a_o`/`mac_b_o`/`mac_c_o` follow the tile inputs. The tile source holds them stable while `tile_valid_i`=1 and unaccepted.
- `res_d_o` is stable while `res_valid_o`=1 and `res_ready_i`=0.
- Reset asserted in any state: IDLE next cycle, in-flight tile and result discarded, no result emitted.
  - The MAC instance shares `rst_i` (inverted to its `rst_ni`), so its pipeline also flushes.
- `cmd_ktiles_i` = 2^KT_W-1 runs the full count; remaining never wraps.

## Test plan
- **Zero tiles:** ktiles=0, all bias elements=5 → `res_valid_o` at cycle after accept, all elements 5; `mac_valid_o` never asserts; `tiles_done_o`=0.
- **Three tiles:** ktiles=3, bias=0, each tile A=identity, B=all 1, behind a MAC with PIPESTAGES=3 → exactly 3 MAC transactions; `mac_c_o` elements 0, then 1, then 2; result all 3; `tiles_done_o`=3.
- **MAC backpressure:** `mac_ready_i`=0 for 4 cycles in ISSUE → `tile_ready_o`=0 those cycles, tile not consumed, `mac_c_o` stable; handshake on cycle 5.
- **Tile gaps / result stall:** `tile_valid_i` low 3 cycles between tiles, then `res_ready_i` low 5 cycles with bias=−1, ktiles=1, A=B=0 → `res_valid_o` held 5 cycles, `res_d_o` elements = 0xFFFFFFFF (P=8), `cmd_ready_o`=0 until after release.
- **Reset mid-operation:** `rst_i` pulsed in WAIT of tile 2/4 → next cycle IDLE, `cmd_ready_o`=1, `busy_o`=0, `tiles_done_o`=0, no `res_valid_o`; a following ktiles=1 command completes normally.
- **Spurious D:** `mac_valid_i`=1 while IDLE → `protocol_err_o`=1 from next cycle, acc unchanged, flag persists until reset.

Source files
------------

// File: rtl/matmul_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : matmul_tile_sequencer
// Description : Drives a K-tiled matrix multiply-accumulate through a single
//               MAC unit. Holds the running MxN accumulator, issues one A/B
//               tile per MAC transaction with C = accumulator, captures D
//               back and emits the final accumulator after the last tile.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_tile_sequencer #(
    parameter int M    = 2,
    parameter int N    = 2,
    parameter int K    = 2,
    parameter int P    = 8,
    parameter int KT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // command
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [KT_W-1:0]      cmd_ktiles_i,
    input  logic [M*N*4*P-1:0]   cmd_bias_i,
    // tile stream
    input  logic                 tile_valid_i,
    output logic                 tile_ready_o,
    input  logic [M*K*P-1:0]     tile_a_i,
    input  logic [K*N*P-1:0]     tile_b_i,
    // MAC input side
    output logic                 mac_valid_o,
    input  logic                 mac_ready_i,
    output logic [M*K*P-1:0]     mac_a_o,
    output logic [K*N*P-1:0]     mac_b_o,
    output logic [M*N*4*P-1:0]   mac_c_o,
    // MAC output side
    input  logic                 mac_valid_i,
    output logic                 mac_ready_o,
    input  logic [M*N*4*P-1:0]   mac_d_i,
    // final result
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [M*N*4*P-1:0]   res_d_o,
    // status
    output logic                 busy_o,
    output logic [KT_W-1:0]      tiles_done_o,
    output logic                 protocol_err_o
);

    localparam int c_a_w = M*K*P;
    localparam int c_b_w = K*N*P;
    localparam int c_c_w = M*N*4*P;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_c_w-1:0]  r_acc;
    logic [KT_W-1:0]   r_remaining;
    logic [KT_W-1:0]   r_tiles_done;
    logic              r_protocol_err;

    logic              w_cmd_fire;
    logic              w_tile_fire;
    logic              w_d_fire;

    // Handshake events; each is only meaningful in its owning state.
    assign w_cmd_fire  = (r_state == S_IDLE)  && cmd_valid_i;
    assign w_tile_fire = (r_state == S_ISSUE) && tile_valid_i && mac_ready_i;
    assign w_d_fire    = (r_state == S_WAIT)  && mac_valid_i;

    assign busy_o         = (r_state != S_IDLE);
    assign tiles_done_o   = r_tiles_done;
    assign protocol_err_o = r_protocol_err;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs; ISSUE is a pure pass-through.
    always_comb begin
        w_state_nxt  = r_state;
        cmd_ready_o  = 1'b0;
        tile_ready_o = 1'b0;
        mac_valid_o  = 1'b0;
        mac_a_o      = '0;
        mac_b_o      = '0;
        mac_c_o      = '0;
        mac_ready_o  = 1'b0;
        res_valid_o  = 1'b0;
        res_d_o      = '0;
        case (r_state)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    w_state_nxt = (cmd_ktiles_i == '0) ? S_OUT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mac_valid_o  = tile_valid_i;
                tile_ready_o = mac_ready_i;
                mac_a_o      = tile_a_i;
                mac_b_o      = tile_b_i;
                mac_c_o      = r_acc;
                if (tile_valid_i && mac_ready_i) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                mac_ready_o = 1'b1;
                if (mac_valid_i) begin
                    w_state_nxt = (r_remaining == '0) ? S_OUT : S_ISSUE;
                end
            end
            S_OUT: begin
                res_valid_o = 1'b1;
                res_d_o     = r_acc;
                if (res_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Accumulator, tile counters and sticky error flag; D is stored bit-exact.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc          <= '0;
            r_remaining    <= '0;
            r_tiles_done   <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_cmd_fire) begin
                r_acc        <= cmd_bias_i;
                r_remaining  <= cmd_ktiles_i;
                r_tiles_done <= '0;
            end
            // Only entered with remaining >= 1, so this never wraps.
            if (w_tile_fire) begin
                r_remaining <= r_remaining - 1'b1;
            end
            if (w_d_fire) begin
                r_acc        <= mac_d_i;
                r_tiles_done <= r_tiles_done + 1'b1;
            end
            // A D result outside WAIT is dropped and flagged until reset.
            if (mac_valid_i && (r_state != S_WAIT)) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    // Operand widths are fixed by the parameters; keep them visibly tied.
    if (c_a_w <= 0 || c_b_w <= 0) begin : g_bad_params
        $error("matmul_tile_sequencer: invalid operand geometry");
    end

endmodule
`default_nettype wire

// File: tb/tb_matmul_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_tile_sequencer
// Description : Directed self-checking bench with a behavioural MAC model
//               (latency 2, i.e. PIPESTAGES=3) and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_tile_sequencer;

    localparam int M       = 2;
    localparam int N       = 2;
    localparam int K       = 2;
    localparam int P       = 8;
    localparam int KT_W    = 8;
    localparam int AW      = M*K*P;
    localparam int BW      = K*N*P;
    localparam int CW      = M*N*4*P;
    localparam int EW      = 4*P;
    localparam int MAC_LAT = 2;
    localparam int TMO     = 200;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              cmd_valid_i, cmd_ready_o;
    logic [KT_W-1:0]   cmd_ktiles_i;
    logic [CW-1:0]     cmd_bias_i;
    logic              tile_valid_i, tile_ready_o;
    logic [AW-1:0]     tile_a_i;
    logic [BW-1:0]     tile_b_i;
    logic              mac_valid_o, mac_ready_i;
    logic [AW-1:0]     mac_a_o;
    logic [BW-1:0]     mac_b_o;
    logic [CW-1:0]     mac_c_o;
    logic              mac_valid_i, mac_ready_o;
    logic [CW-1:0]     mac_d_i;
    logic              res_valid_o, res_ready_i;
    logic [CW-1:0]     res_d_o;
    logic              busy_o;
    logic [KT_W-1:0]   tiles_done_o;
    logic              protocol_err_o;

    // behavioural MAC and stimulus controls
    logic              rdy_ctl;
    logic              spur;
    logic [CW-1:0]     spur_d;
    logic              m_pend, m_out_valid;
    int                m_cnt;
    logic [CW-1:0]     m_d;
    int                mac_tx;

    int                checks   = 0;
    int                failures = 0;
    logic [CW-1:0]     exp_q[$];
    logic [AW-1:0]     ta[$];
    logic [BW-1:0]     tb[$];
    logic [CW-1:0]     exp_acc;

    always #5 clk_i = ~clk_i;

    matmul_tile_sequencer #(.M(M), .N(N), .K(K), .P(P), .KT_W(KT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_ktiles_i(cmd_ktiles_i), .cmd_bias_i(cmd_bias_i),
        .tile_valid_i(tile_valid_i), .tile_ready_o(tile_ready_o),
        .tile_a_i(tile_a_i), .tile_b_i(tile_b_i),
        .mac_valid_o(mac_valid_o), .mac_ready_i(mac_ready_i),
        .mac_a_o(mac_a_o), .mac_b_o(mac_b_o), .mac_c_o(mac_c_o),
        .mac_valid_i(mac_valid_i), .mac_ready_o(mac_ready_o), .mac_d_i(mac_d_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_d_o(res_d_o),
        .busy_o(busy_o), .tiles_done_o(tiles_done_o), .protocol_err_o(protocol_err_o)
    );

    // D = A*B + C with signed P-bit operands, wrapping in 4P bits.
    function automatic logic [CW-1:0] mac_fn(input logic [AW-1:0] a,
                                             input logic [BW-1:0] b,
                                             input logic [CW-1:0] c);
        logic [CW-1:0] d;
        logic [EW-1:0] s, pa, pb;
        logic [P-1:0]  av, bv;
        d = '0;
        for (int r = 0; r < M; r++) begin
            for (int cc = 0; cc < N; cc++) begin
                s = c[(r*N+cc)*EW +: EW];
                for (int k = 0; k < K; k++) begin
                    av = a[(r*K+k)*P +: P];
                    bv = b[(k*N+cc)*P +: P];
                    pa = {{(EW-P){av[P-1]}}, av};
                    pb = {{(EW-P){bv[P-1]}}, bv};
                    s  = s + pa * pb;
                end
                d[(r*N+cc)*EW +: EW] = s;
            end
        end
        return d;
    endfunction

    function automatic logic [CW-1:0] fill_c(input logic [EW-1:0] v);
        logic [CW-1:0] c;
        for (int i = 0; i < M*N; i++) c[i*EW +: EW] = v;
        return c;
    endfunction

    function automatic logic [AW-1:0] ident_a();
        logic [AW-1:0] a;
        a = '0;
        for (int r = 0; r < M; r++) a[(r*K+r)*P +: P] = P'(1);
        return a;
    endfunction

    function automatic logic [BW-1:0] ones_b();
        logic [BW-1:0] b;
        for (int i = 0; i < K*N; i++) b[i*P +: P] = P'(1);
        return b;
    endfunction

    // Behavioural MAC: valid_in -> valid_out latency MAC_LAT, one in flight.
    assign mac_ready_i = rdy_ctl && !m_pend && !m_out_valid;
    assign mac_valid_i = m_out_valid || spur;
    assign mac_d_i     = spur ? spur_d : m_d;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_pend      <= 1'b0;
            m_out_valid <= 1'b0;
            m_cnt       <= 0;
        end else begin
            if (mac_valid_o && mac_ready_i) begin
                m_d    <= mac_fn(mac_a_o, mac_b_o, mac_c_o);
                m_cnt  <= MAC_LAT;
                m_pend <= 1'b1;
                mac_tx <= mac_tx + 1;
            end else if (m_pend) begin
                if (m_cnt == 1) begin
                    m_pend      <= 1'b0;
                    m_out_valid <= 1'b1;
                end
                m_cnt <= m_cnt - 1;
            end
            if (m_out_valid && mac_ready_o) m_out_valid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s timeout observed=none expected=event", tag);
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue_cmd(input logic [KT_W-1:0] kt, input logic [CW-1:0] bias);
        logic [CW-1:0] e;
        int n;
        e = bias;
        for (int i = 0; i < int'(kt); i++) e = mac_fn(ta[i], tb[i], e);
        exp_q.push_back(e);
        exp_acc      = bias;
        cmd_valid_i  = 1'b1;
        cmd_ktiles_i = kt;
        cmd_bias_i   = bias;
        #1;
        n = 0;
        while (!cmd_ready_o && n < TMO) begin @(negedge clk_i); #1; n++; end
        if (n >= TMO) timeout_fail("cmd_accept");
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        #1;
        check("cmd_busy", CW'(busy_o), CW'(1));
        check("cmd_tiles_done_clr", CW'(tiles_done_o), '0);
    endtask

    // Presents the next queued tile; optionally stalls the MAC in ISSUE.
    task automatic feed_tile(input int gap, input int stall);
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        int n;
        a = ta.pop_front();
        b = tb.pop_front();
        repeat (gap) @(negedge clk_i);
        tile_valid_i = 1'b1;
        tile_a_i     = a;
        tile_b_i     = b;
        #1;
        n = 0;
        while (!mac_valid_o && n < TMO) begin @(negedge clk_i); #1; n++; end
        if (n >= TMO) begin
            timeout_fail("tile_issue");
            tile_valid_i = 1'b0;
            return;
        end
        if (stall > 0) begin
            rdy_ctl = 1'b0;
            #1;
            for (int i = 0; i < stall; i++) begin
                check("bp_tile_ready", CW'(tile_ready_o), '0);
                check("bp_mac_c", mac_c_o, exp_acc);
                @(negedge clk_i);
                #1;
            end
            rdy_ctl = 1'b1;
            #1;
        end
        check("issue_tile_ready", CW'(tile_ready_o), CW'(1));
        check("issue_mac_a", CW'(mac_a_o), CW'(a));
        check("issue_mac_b", CW'(mac_b_o), CW'(b));
        check("issue_mac_c", mac_c_o, exp_acc);
        @(posedge clk_i);
        exp_acc = mac_fn(a, b, exp_acc);
        @(negedge clk_i);
        tile_valid_i = 1'b0;
        tile_a_i     = '0;
        tile_b_i     = '0;
    endtask

    // Waits for the result, stalls it, then pops and compares the scoreboard.
    task automatic get_result(input int stall, input int ntiles);
        logic [CW-1:0] e;
        int n;
        #1;
        n = 0;
        while (!res_valid_o && n < TMO) begin @(negedge clk_i); #1; n++; end
        if (n >= TMO) begin
            timeout_fail("res_valid");
            void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < stall; i++) begin
            check("res_hold_valid", CW'(res_valid_o), CW'(1));
            check("res_hold_data", res_d_o, e);
            check("res_hold_cmd_ready", CW'(cmd_ready_o), '0);
            @(negedge clk_i);
            #1;
        end
        res_ready_i = 1'b1;
        #1;
        check("res_data", res_d_o, e);
        check("res_tiles_done", CW'(tiles_done_o), CW'(ntiles));
        check("res_hs_cmd_ready", CW'(cmd_ready_o), '0);
        @(negedge clk_i);
        res_ready_i = 1'b0;
        #1;
        check("post_res_valid", CW'(res_valid_o), '0);
        check("post_res_cmd_ready", CW'(cmd_ready_o), CW'(1));
    endtask

    initial begin
        int tx0;
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx0;
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_ktiles_i = '0; cmd_bias_i = '0;
        tile_valid_i = 1'b0; tile_a_i = '0; tile_b_i = '0; res_ready_i = 1'b0;
        rdy_ctl = 1'b1; spur = 1'b0; spur_d = '0; mac_tx = 0; m_d = '0;
        exp_acc = '0;

        // reset state
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_busy", CW'(busy_o), '0);
        check("rst_tiles_done", CW'(tiles_done_o), '0);
        check("rst_perr", CW'(protocol_err_o), '0);
        check("rst_res_valid", CW'(res_valid_o), '0);
        check("rst_mac_valid", CW'(mac_valid_o), '0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_cmd_ready", CW'(cmd_ready_o), CW'(1));

        // zero tiles: result the cycle after accept, no MAC traffic
        tx0 = mac_tx;
        issue_cmd(8'd0, fill_c(32'd5));
        check("zero_res_now", CW'(res_valid_o), CW'(1));
        get_result(0, 0);
        check("zero_mac_tx", CW'(mac_tx - tx0), '0);

        // three tiles, identity x ones: C = 0,1,2 ; result all 3
        tx0 = mac_tx;
        for (int i = 0; i < 3; i++) begin ta.push_back(ident_a()); tb.push_back(ones_b()); end
        issue_cmd(8'd3, '0);
        for (int i = 0; i < 3; i++) feed_tile(0, 0);
        get_result(0, 3);
        check("three_mac_tx", CW'(mac_tx - tx0), CW'(3));
        check("three_value", fill_c(32'd3), mac_fn(ident_a(), ones_b(), fill_c(32'd2)));

        // MAC backpressure 4 cycles, random operands
        ta.push_back(AW'($urandom)); tb.push_back(BW'($urandom));
        issue_cmd(8'd1, CW'({$urandom, $urandom, $urandom, $urandom}));
        feed_tile(0, 4);
        get_result(0, 1);

        // tile gaps of 3 cycles between random tiles
        for (int i = 0; i < 2; i++) begin ta.push_back(AW'($urandom)); tb.push_back(BW'($urandom)); end
        issue_cmd(8'd2, CW'({$urandom, $urandom, $urandom, $urandom}));
        feed_tile(3, 0);
        feed_tile(3, 0);
        get_result(0, 2);

        // result stall 5 cycles, bias -1, A=B=0
        ta.push_back('0); tb.push_back('0);
        issue_cmd(8'd1, '1);
        feed_tile(0, 0);
        get_result(5, 1);

        // reset while waiting on D of tile 2 of 4
        for (int i = 0; i < 4; i++) begin ta.push_back(AW'($urandom)); tb.push_back(BW'($urandom)); end
        issue_cmd(8'd4, '0);
        feed_tile(0, 0);
        feed_tile(0, 0);
        #1;
        check("mid_wait_mac_ready", CW'(mac_ready_o), CW'(1));
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete(); ta.delete(); tb.delete();
        #1;
        check("mid_rst_cmd_ready", CW'(cmd_ready_o), CW'(1));
        check("mid_rst_busy", CW'(busy_o), '0);
        check("mid_rst_tiles_done", CW'(tiles_done_o), '0);
        for (int i = 0; i < 4; i++) begin
            check("mid_rst_no_res", CW'(res_valid_o), '0);
            @(negedge clk_i);
            #1;
        end
        ta.push_back(AW'($urandom)); tb.push_back(BW'($urandom));
        issue_cmd(8'd1, fill_c(32'd7));
        feed_tile(0, 0);
        get_result(0, 1);

        // spurious D in IDLE and in OUT
        check("spur_pre", CW'(protocol_err_o), '0);
        spur = 1'b1; spur_d = '1;
        @(negedge clk_i);
        spur = 1'b0;
        #1;
        check("spur_idle_flag", CW'(protocol_err_o), CW'(1));
        issue_cmd(8'd0, fill_c(32'h1234_5678));
        spur = 1'b1; spur_d = fill_c(32'hDEAD_BEEF);
        @(negedge clk_i);
        spur = 1'b0;
        get_result(2, 0);
        check("spur_sticky", CW'(protocol_err_o), CW'(1));
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("spur_rst_clear", CW'(protocol_err_o), '0);

        // full tile count: 255 zero tiles, remaining must not wrap
        for (int i = 0; i < 255; i++) begin ta.push_back('0); tb.push_back('0); end
        issue_cmd(8'd255, fill_c(32'd9));
        for (int i = 0; i < 255; i++) feed_tile(0, 0);
        get_result(0, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
